// File: rtl/bomb_flame_ctrl.sv
// Single-bomb controller for a 12x12 tile arena: fuse countdown, cross-shaped
// flame expansion that stops at walls, trees and the grid edge, then flame hold.
module bomb_flame_ctrl #(
    parameter int FUSE_FRAMES  = 120,
    parameter int FLAME_FRAMES = 30,
    parameter int RANGE        = 2
) (
    input  logic         Frame_Clk,
    input  logic         Reset_N,
    input  logic         Place_Req,
    input  logic [9:0]   Place_X,
    input  logic [9:0]   Place_Y,
    input  logic [143:0] Wall_Map,
    input  logic [143:0] Tree_Map,
    output logic [143:0] Bomb_Map,
    output logic [143:0] Flame_Map,
    output logic [143:0] Tree_Hit,
    output logic         Explode,
    output logic         Busy,
    output logic [1:0]   Fsm_State
);

    typedef enum logic [1:0] {IDLE = 2'd0, FUSE = 2'd1, EXPAND = 2'd2, FLAME = 2'd3} state_t;

    state_t         state, next_state;
    logic [15:0]    cnt;
    logic [3:0]     step;
    logic [3:0]     bomb_row, bomb_col;
    logic [7:0]     bomb_idx;
    logic [3:0]     active;
    logic [143:0]   tree_acc;

    // Placement decode: pixel centre to tile coordinates.
    logic [9:0] px_off, py_off, pcol_w, prow_w;
    logic [7:0] place_idx;
    logic       place_in_range, accept;

    assign px_off    = Place_X - 10'd20;
    assign py_off    = Place_Y - 10'd20;
    assign pcol_w    = px_off / 10'd40;
    assign prow_w    = py_off / 10'd40;
    assign place_idx = {4'b0, prow_w[3:0]} * 8'd12 + {4'b0, pcol_w[3:0]};

    assign place_in_range = (Place_X >= 10'd20) && (Place_X <= 10'd460) &&
                            (Place_Y >= 10'd20) && (Place_Y <= 10'd460) &&
                            (pcol_w < 10'd12) && (prow_w < 10'd12);

    assign accept = (state == IDLE) && Place_Req && place_in_range &&
                    !Wall_Map[place_idx] && !Tree_Map[place_idx];

    // Neighbour at distance 'step' in each direction: 0=L, 1=R, 2=U, 3=D.
    logic [4:0] col_plus, row_plus;
    logic [3:0] nb_r [4];
    logic [3:0] nb_c [4];
    logic       nb_in [4];
    logic [7:0] nb_idx [4];

    assign col_plus = {1'b0, bomb_col} + {1'b0, step};
    assign row_plus = {1'b0, bomb_row} + {1'b0, step};

    assign nb_in[0] = step <= bomb_col;
    assign nb_r[0]  = bomb_row;
    assign nb_c[0]  = bomb_col - step;
    assign nb_in[1] = col_plus <= 5'd11;
    assign nb_r[1]  = bomb_row;
    assign nb_c[1]  = col_plus[3:0];
    assign nb_in[2] = step <= bomb_row;
    assign nb_r[2]  = bomb_row - step;
    assign nb_c[2]  = bomb_col;
    assign nb_in[3] = row_plus <= 5'd11;
    assign nb_r[3]  = row_plus[3:0];
    assign nb_c[3]  = bomb_col;

    for (genvar d = 0; d < 4; d++) begin : g_nb_idx
        assign nb_idx[d] = {4'b0, nb_r[d]} * 8'd12 + {4'b0, nb_c[d]};
    end

    logic [143:0] mark_map, hit_map;
    logic [3:0]   deact;

    always_comb begin
        mark_map = '0;
        hit_map  = '0;
        deact    = '0;
        if (state == EXPAND) begin
            for (int d = 0; d < 4; d++) begin
                if (active[d]) begin
                    if (!nb_in[d]) begin
                        deact[d] = 1'b1;
                    end else if (Wall_Map[nb_idx[d]]) begin
                        deact[d] = 1'b1;
                    end else begin
                        mark_map[nb_idx[d]] = 1'b1;
                        if (Tree_Map[nb_idx[d]]) begin
                            hit_map[nb_idx[d]] = 1'b1;
                            deact[d]           = 1'b1;
                        end
                    end
                end
            end
        end
    end

    logic fuse_done, expand_last, flame_done;
    assign fuse_done   = (state == FUSE)   && (cnt == 16'd0);
    assign expand_last = (state == EXPAND) && (step == 4'(RANGE));
    assign flame_done  = (state == FLAME)  && (cnt == 16'd0);

    always_ff @(posedge Frame_Clk or negedge Reset_N) begin
        if (!Reset_N) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)      next_state = FUSE;
            FUSE:    if (fuse_done)   next_state = EXPAND;
            EXPAND:  if (expand_last) next_state = FLAME;
            FLAME:   if (flame_done)  next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    assign Busy      = (state != IDLE);
    assign Fsm_State = state;

    always_ff @(posedge Frame_Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            cnt       <= '0;
            step      <= '0;
            bomb_row  <= '0;
            bomb_col  <= '0;
            bomb_idx  <= '0;
            active    <= '0;
            tree_acc  <= '0;
            Bomb_Map  <= '0;
            Flame_Map <= '0;
            Tree_Hit  <= '0;
            Explode   <= 1'b0;
        end else begin
            Explode  <= 1'b0;
            Tree_Hit <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        Bomb_Map[place_idx] <= 1'b1;
                        bomb_row <= prow_w[3:0];
                        bomb_col <= pcol_w[3:0];
                        bomb_idx <= place_idx;
                        cnt      <= 16'(FUSE_FRAMES - 1);
                    end
                end
                FUSE: begin
                    if (fuse_done) begin
                        Explode             <= 1'b1;
                        Flame_Map[bomb_idx] <= 1'b1;
                        active              <= 4'hF;
                        step                <= 4'd1;
                        tree_acc            <= '0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                EXPAND: begin
                    Flame_Map <= Flame_Map | mark_map;
                    tree_acc  <= tree_acc | hit_map;
                    active    <= active & ~deact;
                    if (expand_last) begin
                        Bomb_Map <= '0;
                        Tree_Hit <= tree_acc | hit_map;
                        cnt      <= 16'(FLAME_FRAMES - 1);
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                FLAME: begin
                    if (flame_done) Flame_Map <= '0;
                    else            cnt <= cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bomb_flame_ctrl.sv
// Directed bench for bomb_flame_ctrl: placement decode, fuse timing, flame
// shape against walls/trees/edges, request rejection and mid-fuse reset.
module tb_bomb_flame_ctrl;

    logic         Frame_Clk = 1'b0;
    logic         Reset_N;
    logic         Place_Req;
    logic [9:0]   Place_X, Place_Y;
    logic [143:0] Wall_Map, Tree_Map;
    logic [143:0] Bomb_Map, Flame_Map, Tree_Hit;
    logic         Explode, Busy;
    logic [1:0]   Fsm_State;

    int total = 0;
    int bad   = 0;

    bomb_flame_ctrl #(.FUSE_FRAMES(120), .FLAME_FRAMES(30), .RANGE(2)) dut (
        .Frame_Clk (Frame_Clk),
        .Reset_N   (Reset_N),
        .Place_Req (Place_Req),
        .Place_X   (Place_X),
        .Place_Y   (Place_Y),
        .Wall_Map  (Wall_Map),
        .Tree_Map  (Tree_Map),
        .Bomb_Map  (Bomb_Map),
        .Flame_Map (Flame_Map),
        .Tree_Hit  (Tree_Hit),
        .Explode   (Explode),
        .Busy      (Busy),
        .Fsm_State (Fsm_State)
    );

    always #5 Frame_Clk = ~Frame_Clk;

    function automatic logic [143:0] bit_of(input int i);
        logic [143:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Frame_Clk);
    endtask

    // Request is seen by exactly one rising edge; returns on the following negedge.
    task automatic place(input logic [9:0] x, input logic [9:0] y);
        Place_X   = x;
        Place_Y   = y;
        Place_Req = 1'b1;
        tick();
        Place_Req = 1'b0;
    endtask

    task automatic wait_explode(input string tag, output int k_found);
        k_found = -1;
        for (int k = 1; k <= 130; k++) begin
            tick();
            if (Explode) begin
                k_found = k;
                break;
            end
        end
        check_int(tag, k_found, 120);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (!Busy) break;
            tick();
        end
        check(tag, {143'b0, Busy}, 144'd0);
    endtask

    initial begin
        int ek;
        int explode_n;
        int busy_n;
        logic [143:0] exp_flame;

        Reset_N   = 1'b0;
        Place_Req = 1'b0;
        Place_X   = '0;
        Place_Y   = '0;
        Wall_Map  = '0;
        Tree_Map  = '0;
        #2;
        check("rst_bomb",  Bomb_Map, '0);
        check("rst_flame", Flame_Map, '0);
        check("rst_ctrl",  {139'b0, Tree_Hit != '0, Explode, Busy, Fsm_State}, '0);
        tick();
        tick();
        Reset_N = 1'b1;
        tick();

        // Centre bomb on empty maps, with a second request during the fuse.
        place(220, 220);
        check("s1_bomb_accept", Bomb_Map, bit_of(65));
        check("s1_busy", {143'b0, Busy}, 144'd1);
        check("s1_state_fuse", {142'b0, Fsm_State}, 144'd1);
        ek        = -1;
        explode_n = 0;
        for (int k = 1; k <= 160; k++) begin
            if (k == 10) begin
                Place_X   = 300;
                Place_Y   = 300;
                Place_Req = 1'b1;
            end
            tick();
            Place_Req = 1'b0;
            if (Explode) begin
                explode_n++;
                if (ek < 0) ek = k;
            end
            if (k == 11)  check("s1_second_req_ignored", Bomb_Map, bit_of(65));
            if (k == 119) check("s1_bomb_held", Bomb_Map, bit_of(65));
            if (k == 120) check("s1_flame_centre", Flame_Map, bit_of(65));
            if (k == 121) check("s1_flame_dist1", Flame_Map,
                                bit_of(65) | bit_of(64) | bit_of(66) | bit_of(53) | bit_of(77));
            if (k == 122) begin
                exp_flame = bit_of(41) | bit_of(53) | bit_of(63) | bit_of(64) | bit_of(65) |
                            bit_of(66) | bit_of(67) | bit_of(77) | bit_of(89);
                check("s1_flame_full", Flame_Map, exp_flame);
                check("s1_bomb_cleared", Bomb_Map, '0);
                check("s1_no_tree_hit", Tree_Hit, '0);
            end
            if (k == 151) check("s1_flame_held", Flame_Map, exp_flame);
            if (k == 152) begin
                check("s1_flame_off", Flame_Map, '0);
                check("s1_idle", {143'b0, Busy}, 144'd0);
            end
        end
        check_int("s1_explode_latency", ek, 120);
        check_int("s1_explode_count", explode_n, 1);

        // Top-left corner: no wrap to 143/131.
        place(20, 20);
        check("s2_bomb_corner", Bomb_Map, bit_of(0));
        wait_explode("s2_explode_latency", ek);
        tick();
        tick();
        check("s2_flame_corner", Flame_Map,
              bit_of(0) | bit_of(1) | bit_of(2) | bit_of(12) | bit_of(24));
        wait_idle("s2_idle");

        // Wall to the left, tree to the right.
        Wall_Map = bit_of(64);
        Tree_Map = bit_of(66);
        place(220, 220);
        wait_explode("s3_explode_latency", ek);
        tick();
        check("s3_tree_hit_not_yet", Tree_Hit, '0);
        check("s3_flame_dist1", Flame_Map, bit_of(65) | bit_of(66) | bit_of(53) | bit_of(77));
        tick();
        check("s3_flame_blocked", Flame_Map,
              bit_of(65) | bit_of(66) | bit_of(53) | bit_of(41) | bit_of(77) | bit_of(89));
        check("s3_tree_hit", Tree_Hit, bit_of(66));
        tick();
        check("s3_tree_hit_pulse", Tree_Hit, '0);
        wait_idle("s3_idle");
        Wall_Map = '0;
        Tree_Map = '0;

        // Rejections.
        place(10, 220);
        check("s4_reject_x", {Bomb_Map[142:0], Busy}, '0);
        place(220, 470);
        check("s4_reject_y", {Bomb_Map[142:0], Busy}, '0);
        Wall_Map = bit_of(65);
        place(220, 220);
        check("s4_reject_wall", {Bomb_Map[142:0], Busy}, '0);
        Wall_Map = '0;

        // Bottom-right boundary placement, then reset at fuse count 50.
        place(460, 460);
        check("s5_bomb_corner", Bomb_Map, bit_of(143));
        for (int k = 1; k <= 69; k++) tick();
        Reset_N = 1'b0;
        #1;
        check("s5_rst_bomb", Bomb_Map, '0);
        check("s5_rst_ctrl", {140'b0, Explode, Busy, Fsm_State}, '0);
        tick();
        tick();
        tick();
        Reset_N   = 1'b1;
        explode_n = 0;
        busy_n    = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (Explode) explode_n++;
            if (Busy) busy_n++;
        end
        check_int("s5_no_explode", explode_n, 0);
        check_int("s5_stays_idle", busy_n, 0);
        check("s5_flame_zero", Flame_Map, '0);

        place(220, 220);
        check("s5_resume", Bomb_Map, bit_of(65));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
